scr_dma_engine: RTL and testbench
=================================

Name: scr_dma_engine

Overview:
- Block-fill and block-copy engine sitting directly upstream of the scratch RAM (256 x 10, combinational read, write on posedge CLK).
- Owns the scratch RAM address, data and write-enable inputs. Muxes CPU accesses with its own.
- The CPU always has priority. The engine stalls in place while the CPU holds the port.
- Used by the RAT computer to clear or copy scratch regions without per-word CPU instructions.

Parameters:
- DATA_W, 10, scratch word width
- ADDR_W, 8, scratch address width (depth 2^ADDR_W)

Ports:
- CLK  in  1  system clock; all state on posedge
- RST  in  1  synchronous, active-high reset
- CPU_REQ  in  1  CPU owns scratch port this cycle
- CPU_ADDR  in  ADDR_W  CPU scratch address
- CPU_DATA  in  DATA_W  CPU write data
- CPU_WE  in  1  CPU write enable (used only when CPU_REQ=1)
- START  in  1  command strobe, sampled only in IDLE
- MODE  in  1  0=fill, 1=copy
- SRC  in  ADDR_W  copy source base
- DST  in  ADDR_W  destination base
- LEN  in  ADDR_W+1  word count, 0..256
- FILL_VAL  in  DATA_W  fill value
- SCR_DATA_OUT  in  DATA_W  scratch RAM read data
- SCR_ADDR  out  ADDR_W  to scratch RAM
- SCR_DATA_IN  out  DATA_W  to scratch RAM
- SCR_WE  out  1  to scratch RAM
- BUSY  out  1  engine not IDLE
- DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset: state=IDLE, BUSY=0, DONE=0, internal counters/latches=0. Engine SCR_WE=0, so SCR_WE equals CPU_REQ&CPU_WE. Reset mid-operation aborts at once with no further engine writes and no DONE.
- Port mux (combinational):
  - CPU_REQ=1 -> SCR_ADDR=CPU_ADDR, SCR_DATA_IN=CPU_DATA, SCR_WE=CPU_WE.
  - Otherwise the engine drives the port. In IDLE/DONE the engine drives SCR_WE=0 and SCR_ADDR=CPU_ADDR.
- States: IDLE, FILL, RD, WR, DONE.
- IDLE:
  - START=1 latches MODE/SRC/DST/LEN/FILL_VAL and sets remaining count CNT=LEN.
  - LEN=0 -> DONE with no writes.
  - MODE=0 -> FILL; MODE=1 -> RD.
  - START outside IDLE is ignored.
- FILL:
  - Each non-stalled cycle: SCR_ADDR=dst ptr, SCR_DATA_IN=FILL_VAL, SCR_WE=1; ptr steps, CNT-1.
  - CNT reaches 0 -> DONE. One word per cycle.
- RD: non-stalled cycle drives SCR_ADDR=src ptr, SCR_WE=0, latches SCR_DATA_OUT into a hold register -> WR.
- WR:
  - Non-stalled cycle drives SCR_ADDR=dst ptr, SCR_DATA_IN=hold, SCR_WE=1; both ptrs step, CNT-1.
  - CNT reaches 0 -> DONE, else -> RD. Two cycles per word.
- Stall: CPU_REQ=1 in FILL/RD/WR freezes all engine state. No latch, no step, no write. The hold register is kept across the stall. Coherence with CPU writes into an active region is not guaranteed.
- DONE: DONE=1 for exactly one cycle -> IDLE. BUSY=1 in FILL/RD/WR/DONE, 0 in IDLE.
- Latency, unstalled, START sampled at edge 0:
  - Fill: writes at cycles 1..LEN, DONE at cycle LEN+1.
  - Copy: DONE at cycle 2*LEN+1.
  - Each CPU_REQ stall cycle adds one cycle.
- Address arithmetic: modulo 2^ADDR_W. Pointers wrap 255->0 (ascending) or 0->255 (descending). LEN=256 touches every location exactly once.

Optional Feature:
- Macro: SCR_DMA_OVERLAP_EN.
- Defined:
  - At START with MODE=1, compute d=(DST-SRC) mod 2^ADDR_W.
  - If d!=0 and d<LEN, the copy runs descending: start at SRC+LEN-1 and DST+LEN-1, decrement pointers.
  - Otherwise ascending. Result always equals the original source block (memmove semantics).
- Not defined:
  - Always ascending; overlapping forward copies propagate already-overwritten data.
  - Fill is unaffected either way.

Test Plan:
- Fill: START, MODE=0, DST=0x10, LEN=4, FILL_VAL=0x3FF -> SCR_WE high cycles 1-4, addrs 0x10-0x13, DONE pulse cycle 5, BUSY low cycle 6.
- Copy: preload 0x20..0x22={1,2,3}; START MODE=1 SRC=0x20 DST=0x40 LEN=3 -> 0x40..0x42={1,2,3}, DONE at cycle 7.
- Wrap and stall:
  - Fill DST=0xFE LEN=4 with CPU_REQ=1 at cycle 2 -> writes 0xFE,0xFF,0x00,0x01.
  - CPU access passes through in cycle 2; DONE at cycle 6.
- Overlap: preload 0x50..0x53={A,B,C,D}; copy SRC=0x50 DST=0x51 LEN=4 -> with SCR_DMA_OVERLAP_EN 0x51..0x54={A,B,C,D}; without, all A.
- Edge cases:
  - LEN=0 -> DONE at cycle 1, no SCR_WE.
  - START while BUSY -> ignored.
  - RST at cycle 3 of a LEN=8 fill -> SCR_WE=0 from next cycle, no DONE, BUSY=0.

Source files
------------

// File: rtl/scr_dma_engine.sv
// Block-fill / block-copy engine in front of the scratch RAM; the CPU always wins the port.
// Optional macro SCR_DMA_OVERLAP_EN: copies whose destination overlaps the source run descending.
module scr_dma_engine #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPU_REQ,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DATA,
  input  logic              CPU_WE,
  input  logic              START,
  input  logic              MODE,
  input  logic [ADDR_W-1:0] SRC,
  input  logic [ADDR_W-1:0] DST,
  input  logic [ADDR_W:0]   LEN,
  input  logic [DATA_W-1:0] FILL_VAL,
  input  logic [DATA_W-1:0] SCR_DATA_OUT,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic [DATA_W-1:0] SCR_DATA_IN,
  output logic              SCR_WE,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [2:0] {StIdle, StFill, StRd, StWr, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   fill_q, fill_d, hold_q, hold_d;
  logic                desc_q, desc_d;
  logic [ADDR_W-1:0]   step;
  logic                last;

`ifdef SCR_DMA_OVERLAP_EN
  logic [ADDR_W-1:0]   dist;
  logic [ADDR_W-1:0]   len_m1;
  assign dist   = DST - SRC;
  assign len_m1 = LEN[ADDR_W-1:0] - ADDR_W'(1);
`endif

  assign step = desc_q ? '1 : ADDR_W'(1);
  assign last = (cnt_q == (ADDR_W+1)'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      desc_q  <= desc_d;
    end
  end

  // A CPU_REQ cycle in FILL/RD/WR leaves every register untouched.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    desc_d  = desc_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          src_d  = SRC;
          dst_d  = DST;
          cnt_d  = LEN;
          fill_d = FILL_VAL;
          desc_d = 1'b0;
`ifdef SCR_DMA_OVERLAP_EN
          if (MODE && (dist != '0) && ({1'b0, dist} < LEN)) begin
            desc_d = 1'b1;
            src_d  = SRC + len_m1;
            dst_d  = DST + len_m1;
          end
`endif
          if (LEN == '0)  state_d = StDone;
          else if (MODE)  state_d = StRd;
          else            state_d = StFill;
        end
      end
      StFill: begin
        if (!CPU_REQ) begin
          dst_d = dst_q + step;
          cnt_d = cnt_q - (ADDR_W+1)'(1);
          if (last) state_d = StDone;
        end
      end
      StRd: begin
        if (!CPU_REQ) begin
          hold_d  = SCR_DATA_OUT;
          state_d = StWr;
        end
      end
      StWr: begin
        if (!CPU_REQ) begin
          src_d   = src_q + step;
          dst_d   = dst_q + step;
          cnt_d   = cnt_q - (ADDR_W+1)'(1);
          state_d = last ? StDone : StRd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    SCR_ADDR    = CPU_ADDR;
    SCR_DATA_IN = CPU_DATA;
    SCR_WE      = 1'b0;
    if (CPU_REQ) begin
      SCR_WE = CPU_WE;
    end else begin
      unique case (state_q)
        StFill: begin
          SCR_ADDR    = dst_q;
          SCR_DATA_IN = fill_q;
          SCR_WE      = 1'b1;
        end
        StRd: SCR_ADDR = src_q;
        StWr: begin
          SCR_ADDR    = dst_q;
          SCR_DATA_IN = hold_q;
          SCR_WE      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state_q != StIdle);
  assign DONE = (state_q == StDone);

endmodule

// File: tb/tb_scr_dma_engine.sv
// Self-checking bench for scr_dma_engine: directed scenarios plus randomized fills/copies with
// random CPU stalls, checked against a word-level memory model.
module tb_scr_dma_engine;

  logic       CLK, RST, CPU_REQ, CPU_WE, START, MODE;
  logic [7:0] CPU_ADDR, SRC, DST, SCR_ADDR;
  logic [9:0] CPU_DATA, FILL_VAL, SCR_DATA_OUT, SCR_DATA_IN;
  logic [8:0] LEN;
  logic       SCR_WE, BUSY, DONE;

  logic [9:0] mem [256];
  logic [9:0] ref_mem [256];
  int checks = 0;
  int failures = 0;

  scr_dma_engine #(.DATA_W(10), .ADDR_W(8)) dut (
    .CLK(CLK), .RST(RST), .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_DATA(CPU_DATA),
    .CPU_WE(CPU_WE), .START(START), .MODE(MODE), .SRC(SRC), .DST(DST), .LEN(LEN),
    .FILL_VAL(FILL_VAL), .SCR_DATA_OUT(SCR_DATA_OUT), .SCR_ADDR(SCR_ADDR),
    .SCR_DATA_IN(SCR_DATA_IN), .SCR_WE(SCR_WE), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scratch RAM: combinational read, write on posedge.
  always @(posedge CLK) if (SCR_WE) mem[SCR_ADDR] <= SCR_DATA_IN;
  assign SCR_DATA_OUT = mem[SCR_ADDR];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [9:0] d);
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = a; CPU_DATA = d;
    tick();
    CPU_REQ = 1'b0; CPU_WE = 1'b0;
    ref_mem[a] = d;
  endtask

  // Leaves the bench in cycle 1 (just after the edge that sampled START).
  task automatic start_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] l, input logic [9:0] f);
    MODE = m; SRC = s; DST = d; LEN = l; FILL_VAL = f; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 8'h33; CPU_DATA = 10'h2A5;
    tick(); tick();
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", DONE); end
    checks++; if (SCR_WE !== 1'b1) begin failures++; $display("FAIL reset_cpu_we: got %b expected 1", SCR_WE); end
    checks++; if (SCR_ADDR !== 8'h33) begin failures++; $display("FAIL reset_cpu_addr: got %h expected 33", SCR_ADDR); end
    checks++; if (SCR_DATA_IN !== 10'h2A5) begin failures++; $display("FAIL reset_cpu_data: got %h expected 2a5", SCR_DATA_IN); end
    CPU_WE = 1'b0; #1;
    checks++; if (SCR_WE !== 1'b0) begin failures++; $display("FAIL reset_cpu_rd_we: got %b expected 0", SCR_WE); end
    tick();
    RST = 1'b0; CPU_REQ = 1'b0; CPU_ADDR = 8'h5C;
    tick();
    @(negedge CLK);
    checks++; if (SCR_WE !== 1'b0) begin failures++; $display("FAIL idle_we: got %b expected 0", SCR_WE); end
    checks++; if (SCR_ADDR !== 8'h5C) begin failures++; $display("FAIL idle_addr: got %h expected 5c", SCR_ADDR); end
    tick();
    for (int i = 0; i < 256; i++) cpu_write(8'(i), 10'h000);
  endtask

  task automatic test_fill;
    start_op(1'b0, 8'h00, 8'h10, 9'd4, 10'h3FF);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      checks++; if (SCR_WE !== (c <= 4)) begin failures++; $display("FAIL fill_we c%0d: got %b expected %b", c, SCR_WE, c <= 4); end
      if (c <= 4) begin
        checks++; if (SCR_ADDR !== 8'(8'h10 + c - 1)) begin failures++; $display("FAIL fill_addr c%0d: got %h expected %h", c, SCR_ADDR, 8'(8'h10 + c - 1)); end
        checks++; if (SCR_DATA_IN !== 10'h3FF) begin failures++; $display("FAIL fill_data c%0d: got %h expected 3ff", c, SCR_DATA_IN); end
      end
      checks++; if (DONE !== (c == 5)) begin failures++; $display("FAIL fill_done c%0d: got %b expected %b", c, DONE, c == 5); end
      checks++; if (BUSY !== (c <= 5)) begin failures++; $display("FAIL fill_busy c%0d: got %b expected %b", c, BUSY, c <= 5); end
      tick();
    end
  endtask

  task automatic test_copy;
    int done_c;
    for (int i = 0; i < 3; i++) cpu_write(8'(8'h20 + i), 10'(i + 1));
    start_op(1'b1, 8'h20, 8'h40, 9'd3, 10'h000);
    done_c = -1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      if (DONE === 1'b1 && done_c < 0) done_c = c;
      tick();
    end
    checks++; if (done_c != 7) begin failures++; $display("FAIL copy_done_cycle: got %0d expected 7", done_c); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[8'h40 + i] !== 10'(i + 1)) begin failures++; $display("FAIL copy_data[%0d]: got %h expected %h", i, mem[8'h40 + i], 10'(i + 1)); end
    end
  endtask

  task automatic test_wrap_stall;
    logic [7:0] wa [4];
    int done_c;
    wa[0] = 8'hFE; wa[1] = 8'hFF; wa[2] = 8'h00; wa[3] = 8'h01;
    start_op(1'b0, 8'h00, 8'hFE, 9'd4, 10'h2AA);
    done_c = -1;
    for (int c = 1; c <= 8; c++) begin
      CPU_REQ = (c == 2); CPU_WE = (c == 2); CPU_ADDR = 8'h80; CPU_DATA = 10'h155;
      @(negedge CLK);
      if (c == 2) begin
        checks++; if (SCR_ADDR !== 8'h80 || SCR_WE !== 1'b1 || SCR_DATA_IN !== 10'h155) begin
          failures++; $display("FAIL stall_passthru: got addr %h we %b data %h expected 80 1 155", SCR_ADDR, SCR_WE, SCR_DATA_IN);
        end
      end
      if (DONE === 1'b1 && done_c < 0) done_c = c;
      tick();
    end
    CPU_REQ = 1'b0; CPU_WE = 1'b0;
    checks++; if (done_c != 6) begin failures++; $display("FAIL wrap_done_cycle: got %0d expected 6", done_c); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[wa[i]] !== 10'h2AA) begin failures++; $display("FAIL wrap_data[%h]: got %h expected 2aa", wa[i], mem[wa[i]]); end
    end
    checks++; if (mem[8'h80] !== 10'h155) begin failures++; $display("FAIL wrap_cpu_write: got %h expected 155", mem[8'h80]); end
    checks++; if (mem[8'h02] !== 10'h000 || mem[8'hFD] !== 10'h000) begin
      failures++; $display("FAIL wrap_bounds: got %h %h expected 000 000", mem[8'h02], mem[8'hFD]);
    end
  endtask

  task automatic test_overlap;
    logic [9:0] src_v [4];
    logic [9:0] exp_v [4];
    logic seen;
    src_v[0] = 10'h10A; src_v[1] = 10'h20B; src_v[2] = 10'h30C; src_v[3] = 10'h00D;
    for (int i = 0; i < 4; i++) cpu_write(8'(8'h50 + i), src_v[i]);
`ifdef SCR_DMA_OVERLAP_EN
    for (int i = 0; i < 4; i++) exp_v[i] = src_v[i];
`else
    for (int i = 0; i < 4; i++) exp_v[i] = src_v[0];
`endif
    start_op(1'b1, 8'h50, 8'h51, 9'd4, 10'h000);
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge CLK);
      seen = (DONE === 1'b1);
      tick();
    end
    checks++; if (!seen) begin failures++; $display("FAIL overlap_done: got none expected pulse"); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[8'h51 + i] !== exp_v[i]) begin failures++; $display("FAIL overlap_data[%0d]: got %h expected %h", i, mem[8'h51 + i], exp_v[i]); end
    end
  endtask

  task automatic test_len0;
    start_op(1'b0, 8'h00, 8'h30, 9'd0, 10'h3FF);
    @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL len0_done: got %b expected 1", DONE); end
    checks++; if (SCR_WE !== 1'b0) begin failures++; $display("FAIL len0_we: got %b expected 0", SCR_WE); end
    tick();
    @(negedge CLK);
    checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL len0_idle: got done %b busy %b expected 0 0", DONE, BUSY); end
    checks++; if (mem[8'h30] !== 10'h000) begin failures++; $display("FAIL len0_mem: got %h expected 000", mem[8'h30]); end
    tick();
  endtask

  task automatic test_start_busy;
    int done_c;
    start_op(1'b0, 8'h00, 8'h60, 9'd3, 10'h111);
    done_c = -1;
    for (int c = 1; c <= 6; c++) begin
      START = (c == 2); MODE = 1'b0; DST = 8'h70; LEN = 9'd2; FILL_VAL = 10'h222;
      @(negedge CLK);
      if (DONE === 1'b1 && done_c < 0) done_c = c;
      tick();
    end
    START = 1'b0;
    checks++; if (done_c != 4) begin failures++; $display("FAIL busy_start_done: got %0d expected 4", done_c); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[8'h60 + i] !== 10'h111) begin failures++; $display("FAIL busy_start_fill[%0d]: got %h expected 111", i, mem[8'h60 + i]); end
    end
    checks++; if (mem[8'h70] !== 10'h000 || mem[8'h63] !== 10'h000) begin
      failures++; $display("FAIL busy_start_ignored: got %h %h expected 000 000", mem[8'h70], mem[8'h63]);
    end
  endtask

  task automatic test_reset_mid;
    start_op(1'b0, 8'h00, 8'h90, 9'd8, 10'h3C3);
    for (int c = 1; c <= 12; c++) begin
      RST = (c == 3);
      @(negedge CLK);
      if (c >= 4) begin
        checks++; if (SCR_WE !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
          failures++; $display("FAIL rst_mid c%0d: got we %b done %b busy %b expected 0 0 0", c, SCR_WE, DONE, BUSY);
        end
      end
      tick();
    end
    RST = 1'b0;
    checks++; if (mem[8'h92] !== 10'h3C3) begin failures++; $display("FAIL rst_mid_last: got %h expected 3c3", mem[8'h92]); end
    checks++; if (mem[8'h93] !== 10'h000 || mem[8'h97] !== 10'h000) begin
      failures++; $display("FAIL rst_mid_abort: got %h %h expected 000 000", mem[8'h93], mem[8'h97]);
    end
  endtask

  // Word-level model: fill, or memcpy (forward) / memmove depending on the build.
  task automatic model_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] l, input logic [9:0] f);
    logic [9:0] tmp [256];
    if (!m) begin
      for (int i = 0; i < int'(l); i++) ref_mem[8'(int'(d) + i)] = f;
    end else begin
`ifdef SCR_DMA_OVERLAP_EN
      for (int i = 0; i < int'(l); i++) tmp[i] = ref_mem[8'(int'(s) + i)];
      for (int i = 0; i < int'(l); i++) ref_mem[8'(int'(d) + i)] = tmp[i];
`else
      for (int i = 0; i < int'(l); i++) ref_mem[8'(int'(d) + i)] = ref_mem[8'(int'(s) + i)];
`endif
    end
  endtask

  task automatic test_random;
    logic       m;
    logic [7:0] s, d;
    logic [8:0] l;
    logic [9:0] f;
    int work, limit, bad_c, diffs, first_diff;
    logic timing_ok, exp_done;
    for (int i = 0; i < 256; i++) cpu_write(8'(i), 10'($urandom));
    for (int op = 0; op < 14; op++) begin
      m = 1'($urandom_range(0, 1));
      s = 8'($urandom);
      d = 8'($urandom);
      if (m) l = 9'($urandom_range(0, 128));
      else   l = ($urandom_range(0, 5) == 0) ? 9'd256 : 9'($urandom_range(0, 40));
      if (op == 0) begin m = 1'b1; d = s + 8'd3; l = 9'd20; end
      if (op == 1) begin m = 1'b0; l = 9'd256; end
      f = 10'($urandom);
      model_op(m, s, d, l, f);
      work = m ? 2 * int'(l) : int'(l);
      limit = 4 * work + 50;
      start_op(m, s, d, l, f);
      timing_ok = 1'b1; bad_c = 0; exp_done = 1'b0;
      for (int c = 1; c <= limit; c++) begin
        CPU_REQ = (work > 0) && ($urandom_range(0, 3) == 0);
        CPU_WE = 1'b0; CPU_ADDR = 8'($urandom);
        exp_done = (work == 0);
        @(negedge CLK);
        if (DONE !== exp_done && timing_ok) begin timing_ok = 1'b0; bad_c = c; end
        if (!CPU_REQ && work > 0) work--;
        tick();
        if (exp_done) break;
      end
      CPU_REQ = 1'b0;
      checks++; if (!timing_ok || !exp_done) begin
        failures++; $display("FAIL rand_done op%0d: got done %b at cycle %0d expected %b", op, DONE, bad_c, !DONE);
      end
      diffs = 0; first_diff = -1;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) begin
        diffs++; if (first_diff < 0) first_diff = i;
      end
      checks++; if (diffs != 0) begin
        failures++;
        $display("FAIL rand_mem op%0d: got %0d wrong words (first %h = %h) expected 0 (%h)",
                 op, diffs, first_diff, mem[first_diff], ref_mem[first_diff]);
      end
    end
  endtask

  initial begin
    RST = 1'b1; CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DATA = '0;
    START = 1'b0; MODE = 1'b0; SRC = '0; DST = '0; LEN = '0; FILL_VAL = '0;
    #1;
    test_reset();
    test_fill();
    test_copy();
    test_wrap_stall();
    test_overlap();
    test_len0();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
